// File: rtl/divider_pkg.sv
// Shared CPU definitions used by the divide unit and the EX/MEM HI/LO path.
package divider_pkg;

  localparam int DIV_DATA_WIDTH = 32;

  // Divide unit state encoding.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_END  = 2'd3
  } div_state_t;

  // Source selection for the HI/LO register write port in EX/MEM.
  typedef enum logic [1:0] {
    HILO_SRC_NONE = 2'd0,
    HILO_SRC_MULT = 2'd1,
    HILO_SRC_DIV  = 2'd2,
    HILO_SRC_MOVE = 2'd3
  } hilo_src_t;

endpackage

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring DIV/DIVU unit; HI = remainder, LO = quotient.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DIV_IDLE | waiting for start; results hold last values
// DIV_ZERO | divisor was zero; one cycle, then END with zero results
// DIV_ON   | one quotient bit per clock, DATA_WIDTH steps
// DIV_END  | results valid, ready high until start drops
module divider
  import divider_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  annul,
  output logic                  busy,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic [DATA_WIDTH-1:0] result_lo
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  div_state_t state, state_nxt;

  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic                  sdiv_q, sign_a_q, sign_b_q;

  logic [DATA_WIDTH-1:0] a_abs, b_abs;
  logic [DATA_WIDTH-1:0] step_rem, step_quo, fin_rem, fin_quo;

  // One restoring step: shift in the next dividend bit, trial-subtract
  // with a DATA_WIDTH+1 bit difference so the borrow is visible.
  function automatic logic [2*DATA_WIDTH-1:0] div_step(
    input logic [DATA_WIDTH-1:0] rem_in,
    input logic [DATA_WIDTH-1:0] quo_in,
    input logic [DATA_WIDTH-1:0] dsr
  );
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;
    shifted = {rem_in, quo_in[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, dsr};
    if (diff[DATA_WIDTH])
      return {shifted[DATA_WIDTH-1:0], quo_in[DATA_WIDTH-2:0], 1'b0};
    else
      return {diff[DATA_WIDTH-1:0], quo_in[DATA_WIDTH-2:0], 1'b1};
  endfunction

  // Operand magnitudes; the most negative value maps onto itself and is
  // then treated as an unsigned magnitude.
  always_comb begin
    a_abs = (signed_div && operand_a[DATA_WIDTH-1]) ? -operand_a : operand_a;
    b_abs = (signed_div && operand_b[DATA_WIDTH-1]) ? -operand_b : operand_b;
  end

  // Next iteration values and the sign-corrected final results.
  always_comb begin
    {step_rem, step_quo} = div_step(rem_q, quo_q, dsr_q);
    fin_quo = (sdiv_q && (sign_a_q ^ sign_b_q)) ? -step_quo : step_quo;
    fin_rem = (sdiv_q && sign_a_q) ? -step_rem : step_rem;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= DIV_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ready     = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start && !annul)
          state_nxt = (operand_b == '0) ? DIV_ZERO : DIV_ON;
      end
      DIV_ZERO: begin
        busy      = 1'b1;
        state_nxt = annul ? DIV_IDLE : DIV_END;
      end
      DIV_ON: begin
        busy = 1'b1;
        if (annul)                  state_nxt = DIV_IDLE;
        else if (cnt == LAST_STEP)  state_nxt = DIV_END;
      end
      DIV_END: begin
        ready = 1'b1;
        if (!start) state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration registers and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      sdiv_q    <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start && !annul) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= a_abs;
            dsr_q    <= b_abs;
            sdiv_q   <= signed_div;
            sign_a_q <= signed_div & operand_a[DATA_WIDTH-1];
            sign_b_q <= signed_div & operand_b[DATA_WIDTH-1];
          end
        end
        DIV_ZERO: begin
          if (!annul) begin
            result_hi <= '0;
            result_lo <= '0;
          end
        end
        DIV_ON: begin
          if (!annul) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_STEP) begin
              result_hi <= fin_rem;
              result_lo <= fin_quo;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Multi-cycle DIV/DIVU unit: the responder side of the EX-stage request/stall handshake.
- EX initiates a divide and holds the pipeline until this block signals completion.
- Results go to the HI/LO write path: HI = remainder, LO = quotient.
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- DATA_WIDTH, 32, operand and result width; iteration count equals DATA_WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  EX request; level-held until ready is seen.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- operand_a  in  DATA_WIDTH  dividend (rs).
- operand_b  in  DATA_WIDTH  divisor (rt).
- annul  in  1  abort the current operation (flush on exception/branch).
- busy  out  1  operation in progress; EX uses it as a stall request.
- ready  out  1  result valid.
- result_hi  out  DATA_WIDTH  remainder.
- result_lo  out  DATA_WIDTH  quotient.

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; busy=0, ready=0, result_hi=0, result_lo=0; counter and datapath registers cleared.
- States: IDLE, DIV_ZERO, ON, END.
- IDLE:
  - start=1 and annul=0 with operand_b==0 -> DIV_ZERO.
  - start=1 and annul=0 with operand_b!=0 -> ON.
  - On entry to ON: latch absolute values (signed_div=1) or raw values (signed_div=0), latch signed_div and both operand signs, clear counter.
- ON:
  - Each edge performs one shift/trial-subtract step; counter increments.
  - After DATA_WIDTH steps -> END.
- DIV_ZERO: next edge -> END with quotient=0, remainder=0.
- END:
  - Apply sign fix when signed_div=1:
    - quotient negated iff dividend and divisor signs differ;
    - remainder takes the dividend's sign.
  - ready=1 and results valid while in END.
  - Stays in END while start=1; start=0 -> IDLE, ready drops.
  - result_hi/result_lo keep their last values in IDLE.
- busy=1 in DIV_ZERO and ON; 0 in IDLE and END.
- Latency:
  - Nonzero divisor: ready first high after the (DATA_WIDTH+1)th edge following the edge that samples start, i.e. 33 edges at default.
  - Zero divisor: ready after 2 edges.
- annul=1 in DIV_ZERO or ON -> IDLE on the next edge; ready never asserts; results unchanged.
- annul has priority over start in IDLE.
- Operands are sampled only on leaving IDLE; input changes during ON are ignored.
- Width rules:
  - Trial subtraction is DATA_WIDTH+1 bits.
  - abs(0x80000000) is treated as unsigned 0x80000000, so signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no trap.
- Asynchronous reset in any state returns to IDLE immediately; outputs take reset values.

Decomposition:
- Shared cpu package holds:
  - state encoding constants (DIV_IDLE, DIV_ZERO, DIV_ON, DIV_END);
  - DATA_WIDTH default;
  - the HI/LO write-source encoding used by EX/MEM.
- No sub-module. The single-step restoring subtractor is an inline combinational function.

Test Plan:
- DIVU 0x00000011 / 0x00000003 -> ready after 33 edges, result_lo=0x00000005, result_hi=0x00000002, busy high for 32 cycles.
- DIV 0xFFFFFFE2 (-30) / 0x00000006 -> result_lo=0xFFFFFFFB, result_hi=0x00000000.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF; DIVU of the same operands -> result_lo=0x7FFFFFFC, result_hi=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> result_lo=0x80000000, result_hi=0; any operand / 0x00000000 -> ready after 2 edges, both results 0.
- start held, annul pulsed at iteration 10 -> IDLE next edge, ready stays 0, results keep prior values; a new DIVU 100/7 afterwards -> LO=14, HI=2.
- reset driven low mid-operation (iteration 20), asynchronous to clock -> busy=0, ready=0, results 0 immediately; release, then start -> normal completion.
